// File: rtl/isq_alloc_ctl_pkg.sv
// Shared sizing and helpers for the issue-queue allocation controller.
// The group-free vector is derived from registered line occupancy only.
package isq_pkg;

  localparam int ISQ_DEPTH    = 64;
  localparam int INST_PORT    = 4;
  localparam int GRP_NUM      = ISQ_DEPTH / INST_PORT;
  localparam int GRP_IDX_BITS = $clog2(GRP_NUM);

  typedef logic [ISQ_DEPTH-1:0]    lin_vec_t;
  typedef logic [GRP_NUM-1:0]      grp_vec_t;
  typedef logic [GRP_IDX_BITS-1:0] grp_idx_t;
  typedef logic [GRP_IDX_BITS:0]   grp_cnt_t;

  function automatic grp_vec_t grp_free_vec(input lin_vec_t occ);
    grp_vec_t v;
    v = '0;
    for (int g = 0; g < GRP_NUM; g++) begin
      v[g] = (occ[g*INST_PORT +: INST_PORT] == {INST_PORT{1'b0}});
    end
    return v;
  endfunction

  function automatic grp_cnt_t grp_popcnt(input grp_vec_t v);
    grp_cnt_t cnt;
    cnt = '0;
    for (int g = 0; g < GRP_NUM; g++) begin
      cnt = cnt + grp_cnt_t'(v[g]);
    end
    return cnt;
  endfunction

endpackage

// File: rtl/isq_alloc_ctl_if.sv
// Dispatch / queue-write / occupancy bundle between the dispatch side and
// the allocation controller.
interface isq_alloc_ctl_if;
  import isq_pkg::*;

  logic     dis_vld;
  logic     dis_rdy;
  logic     fls;
  lin_vec_t lin_free;
  lin_vec_t isq_lin_en;
  logic     isq_en;
  grp_idx_t alloc_grp;
  lin_vec_t lin_occ;
  grp_cnt_t free_grp_cnt;
  logic     full;
  logic     empty;

  modport master (
    output dis_vld, fls, lin_free,
    input  dis_rdy, isq_lin_en, isq_en, alloc_grp, lin_occ, free_grp_cnt, full, empty
  );

  modport slave (
    input  dis_vld, fls, lin_free,
    output dis_rdy, isq_lin_en, isq_en, alloc_grp, lin_occ, free_grp_cnt, full, empty
  );

endinterface

// File: rtl/isq_alloc_ctl_grp_pick.sv
// Round-robin picker: first set bit of free_i at or above ptr_i, wrapping.
// The vector is doubled so a single lowest-bit encode covers the wrap.
module isq_grp_pick
  import isq_pkg::*;
(
  input  grp_vec_t free_i,
  input  grp_idx_t ptr_i,
  output logic     found_o,
  output grp_idx_t idx_o
);

  localparam int DW = 2 * GRP_NUM;
  localparam int PW = $clog2(DW);

  logic [DW-1:0] dbl_s;
  logic [DW-1:0] mask_s;
  logic [DW-1:0] hit_s;
  logic [PW-1:0] pos_s;

  assign dbl_s  = {free_i, free_i};
  assign mask_s = ~(({{(DW-1){1'b0}}, 1'b1} << ptr_i) - {{(DW-1){1'b0}}, 1'b1});
  assign hit_s  = dbl_s & mask_s;

  // Descending scan so the lowest hit is the final assignment.
  always_comb begin
    pos_s = '0;
    for (int i = DW - 1; i >= 0; i--) begin
      if (hit_s[i]) begin
        pos_s = PW'(i);
      end else begin
        pos_s = pos_s;
      end
    end
  end

  assign found_o = |free_i;
  assign idx_o   = pos_s[GRP_IDX_BITS-1:0];

endmodule

// File: rtl/isq_alloc_ctl.sv
// Issue-queue allocation controller: picks a free aligned line group per
// dispatch group, drives the queue write enables and tracks occupancy.
module isq_alloc_ctl
  import isq_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  isq_alloc_ctl_if.slave  bus
);

  lin_vec_t occ_q, occ_d;
  grp_idx_t rr_q,  rr_d;
  grp_cnt_t cnt_q, cnt_d;

  grp_vec_t free_vec_s;
  logic     pick_found_s;
  grp_idx_t pick_idx_s;
  logic     rdy_s;
  logic     acc_s;
  lin_vec_t alloc_mask_s;

  assign free_vec_s = grp_free_vec(occ_q);

  isq_grp_pick u_pick (
    .free_i  (free_vec_s),
    .ptr_i   (rr_q),
    .found_o (pick_found_s),
    .idx_o   (pick_idx_s)
  );

  // Accept decode; rst_n gating keeps the queue from being written during reset.
  always_comb begin
    rdy_s        = rst_n && (cnt_q != grp_cnt_t'(0)) && !bus.fls;
    acc_s        = bus.dis_vld && rdy_s && pick_found_s;
    alloc_mask_s = '0;
    if (acc_s) begin
      alloc_mask_s = lin_vec_t'({INST_PORT{1'b1}}) << (int'(pick_idx_s) * INST_PORT);
    end else begin
      alloc_mask_s = '0;
    end
  end

  // Next state: flush wins, then allocation set over release clear.
  always_comb begin
    occ_d = occ_q;
    rr_d  = rr_q;
    if (bus.fls) begin
      occ_d = '0;
      rr_d  = '0;
    end else begin
      occ_d = (occ_q & ~bus.lin_free) | alloc_mask_s;
      if (acc_s) begin
        rr_d = pick_idx_s + grp_idx_t'(1);
      end else begin
        rr_d = rr_q;
      end
    end
    cnt_d = grp_popcnt(grp_free_vec(occ_d));
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ_q <= '0;
      rr_q  <= '0;
      cnt_q <= grp_cnt_t'(GRP_NUM);
    end else begin
      occ_q <= occ_d;
      rr_q  <= rr_d;
      cnt_q <= cnt_d;
    end
  end

  assign bus.dis_rdy      = rdy_s;
  assign bus.isq_en       = acc_s;
  assign bus.isq_lin_en   = alloc_mask_s;
  assign bus.alloc_grp    = acc_s ? pick_idx_s : rr_q;
  assign bus.lin_occ      = occ_q;
  assign bus.free_grp_cnt = cnt_q;
  assign bus.full         = (cnt_q == grp_cnt_t'(0));
  assign bus.empty        = (occ_q == '0);

endmodule

// File: tb/tb_isq_alloc_ctl.sv
// Scoreboard bench for isq_alloc_ctl: directed scenarios plus random traffic
// checked against a line-array reference model.
module tb_isq_alloc_ctl;

  typedef struct {
    bit acc;
    bit rdy;
    int g;
  } exp_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  bit   mon_en;
  exp_t exp_q[$];

  logic [63:0] m_occ;
  int          m_rr;

  isq_alloc_ctl_if bus ();

  isq_alloc_ctl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  function automatic bit grp_is_free(input logic [63:0] o, input int g);
    for (int k = 0; k < 4; k++) begin
      if (o[g*4+k]) return 1'b0;
    end
    return 1'b1;
  endfunction

  function automatic int nfree(input logic [63:0] o);
    int n = 0;
    for (int g = 0; g < 16; g++) begin
      if (grp_is_free(o, g)) n++;
    end
    return n;
  endfunction

  function automatic int pick(input logic [63:0] o, input int rr);
    for (int k = 0; k < 16; k++) begin
      if (grp_is_free(o, (rr + k) % 16)) return (rr + k) % 16;
    end
    return -1;
  endfunction

  // One clock of stimulus: predict, enqueue, drive, advance model, check state.
  task automatic cycle(input bit vld, input bit f, input logic [63:0] fr);
    exp_t e;
    e.rdy = (nfree(m_occ) != 0) && !f;
    e.acc = vld && e.rdy;
    e.g   = e.acc ? pick(m_occ, m_rr) : m_rr;
    mon_en = 1'b1;
    exp_q.push_back(e);
    bus.dis_vld  = vld;
    bus.fls      = f;
    bus.lin_free = fr;
    @(posedge clk);
    if (f) begin
      m_occ = '0;
      m_rr  = 0;
    end else begin
      for (int i = 0; i < 64; i++) begin
        if (fr[i]) m_occ[i] = 1'b0;
      end
      if (e.acc) begin
        for (int k = 0; k < 4; k++) m_occ[e.g*4+k] = 1'b1;
        m_rr = (e.g + 1) % 16;
      end
    end
    #1;
    chk("lin_occ", bus.lin_occ, m_occ);
    chk("free_grp_cnt", 64'(bus.free_grp_cnt), 64'(nfree(m_occ)));
    chk("full", 64'(bus.full), 64'(nfree(m_occ) == 0));
    chk("empty", 64'(bus.empty), 64'(m_occ == 64'd0));
  endtask

  // Monitor: pops one expectation per clock and compares the write outputs.
  always @(negedge clk) begin
    if (mon_en) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL scoreboard_underflow isq_en=%0b", bus.isq_en);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("dis_rdy", 64'(bus.dis_rdy), 64'(e.rdy));
        chk("isq_en", 64'(bus.isq_en), 64'(e.acc));
        if (e.acc) begin
          chk("alloc_grp", 64'(bus.alloc_grp), 64'(e.g));
          chk("isq_lin_en", bus.isq_lin_en, 64'hF << (4 * e.g));
        end else begin
          chk("isq_lin_en_idle", bus.isq_lin_en, 64'd0);
        end
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_isq_en"}, 64'(bus.isq_en), 64'd0);
    chk({tag, "_isq_lin_en"}, bus.isq_lin_en, 64'd0);
    chk({tag, "_alloc_grp"}, 64'(bus.alloc_grp), 64'd0);
    chk({tag, "_lin_occ"}, bus.lin_occ, 64'd0);
    chk({tag, "_free_grp_cnt"}, 64'(bus.free_grp_cnt), 64'd16);
    chk({tag, "_full"}, 64'(bus.full), 64'd0);
    chk({tag, "_empty"}, 64'(bus.empty), 64'd1);
  endtask

  initial begin
    logic [63:0] fr;
    checks       = 0;
    errors       = 0;
    mon_en       = 1'b0;
    m_occ        = '0;
    m_rr         = 0;
    rst_n        = 1'b0;
    bus.dis_vld  = 1'b0;
    bus.fls      = 1'b0;
    bus.lin_free = '0;
    #22;
    check_reset_outputs("reset");
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Fill all 16 groups in order.
    for (int i = 0; i < 16; i++) cycle(1'b1, 1'b0, 64'd0);
    chk("full_after_fill", 64'(bus.full), 64'd1);
    chk("cnt_after_fill", 64'(bus.free_grp_cnt), 64'd0);

    // Free group 5 in one cycle, then allocate it.
    cycle(1'b0, 1'b0, 64'hF << 20);
    chk("cnt_one_free", 64'(bus.free_grp_cnt), 64'd1);
    cycle(1'b1, 1'b0, 64'd0);

    // Partial free keeps group 5 occupied until its last line goes.
    cycle(1'b0, 1'b0, 64'h7 << 20);
    chk("full_partial_free", 64'(bus.full), 64'd1);
    cycle(1'b1, 1'b0, 64'd0);
    cycle(1'b0, 1'b0, 64'h1 << 23);
    cycle(1'b1, 1'b0, 64'd0);

    // Steer rr_ptr to 14, free groups 0, 3, 15 and check wrap order.
    cycle(1'b0, 1'b0, 64'hF << 52);
    cycle(1'b1, 1'b0, 64'd0);
    cycle(1'b0, 1'b0, (64'hF << 0) | (64'hF << 12) | (64'hF << 60));
    cycle(1'b1, 1'b0, 64'd0);
    cycle(1'b1, 1'b0, 64'd0);
    cycle(1'b1, 1'b0, 64'd0);

    // Flush during dispatch with a half-full queue.
    cycle(1'b0, 1'b1, 64'd0);
    for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0, 64'd0);
    cycle(1'b1, 1'b1, 64'd0);
    chk("empty_after_fls", 64'(bus.empty), 64'd1);
    cycle(1'b1, 1'b0, 64'd0);

    // Release pulses on lines that are not occupied.
    cycle(1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFF0 & ~(64'hF << 4));
    cycle(1'b0, 1'b0, 64'hFFFF_0000_0000_0000);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      fr = {$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom};
      if ($urandom_range(0, 7) == 0) fr = fr | (64'hF << (4 * $urandom_range(0, 15)));
      cycle(($urandom_range(0, 3) != 0), ($urandom_range(0, 63) == 0), fr);
    end

    // Reset asserted mid-burst.
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 64'd0);
    mon_en       = 1'b0;
    bus.dis_vld  = 1'b1;
    bus.fls      = 1'b0;
    bus.lin_free = '0;
    rst_n        = 1'b0;
    #1;
    check_reset_outputs("midrst");
    @(posedge clk);
    #1;
    check_reset_outputs("midrst_edge");
    rst_n = 1'b1;
    m_occ = '0;
    m_rr  = 0;
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 64'd0);
    cycle(1'b0, 1'b0, 64'd0);

    mon_en = 1'b0;
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
